bloom_filter_lut_ctrl: RTL

Control and configuration block for the bloom filter. It terminates the Avalon-MM CSR port and holds the filter configuration (enable, string-length window, hash mask), and counts matches. It shares the per-hash LUT write port between host LUT programming and an internal clear sweep that zeroes all LUTs. Its outputs configure and gate the hashing/lookup datapath.

---
 rtl/bloom_filter_lut_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/bloom_filter_lut_ctrl.sv
// bloom_filter_lut_ctrl: CSR termination, filter configuration, match counter and LUT write arbitration with clear sweep
module bloom_filter_lut_ctrl #(
  parameter int AMM_CSR_DATA_W = 32,
  parameter int AMM_CSR_ADDR_W = 32,
  parameter int AMM_LUT_DATA_W = 32,
  parameter int AMM_LUT_ADDR_W = 32,
  parameter int LUT_ADDR_W     = 10,
  parameter int HASHES_CNT     = 6,
  parameter int MIN_STR_SIZE   = 3,
  parameter int MAX_STR_SIZE   = 20
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic [AMM_CSR_ADDR_W-1:0] csr_address_i,
  input  logic                      csr_read_i,
  input  logic                      csr_write_i,
  input  logic [AMM_CSR_DATA_W-1:0] csr_writedata_i,
  output logic [AMM_CSR_DATA_W-1:0] csr_readdata_o,
  output logic                      csr_readdatavalid_o,
  input  logic [AMM_LUT_ADDR_W-1:0] lut_host_address_i,
  input  logic                      lut_host_write_i,
  input  logic [AMM_LUT_DATA_W-1:0] lut_host_writedata_i,
  output logic                      lut_host_waitrequest_o,
  output logic                      lut_wr_o,
  output logic [HASHES_CNT-1:0]     lut_wr_hash_o,
  output logic [LUT_ADDR_W-1:0]     lut_wr_addr_o,
  output logic                      lut_wr_data_o,
  output logic                      filter_en_o,
  output logic [7:0]                min_str_size_o,
  output logic [7:0]                max_str_size_o,
  output logic [HASHES_CNT-1:0]     hash_mask_o,
  input  logic                      match_i
);
  localparam logic [1:0] S_IDLE = 2'd0, S_ARM = 2'd1, S_RUN = 2'd2;
  logic [1:0]                r_state, w_state_nxt;
  logic                      r_en, r_err;
  logic [31:0]               r_match_cnt;
  logic                      w_busy, w_wr_ctrl, w_wr_stat, w_wr_str, w_wr_cnt, w_wr_mask;
  logic                      w_str_ok, w_hash_ok, w_en_nxt, w_unused;
  logic [2:0]                w_a;
  logic [7:0]                w_smin, w_smax, w_hash_idx;
  logic [AMM_CSR_DATA_W-1:0] w_rdata;
  assign w_a       = csr_address_i[2:0];
  assign w_busy    = r_state != S_IDLE;
  assign w_wr_ctrl = csr_write_i && w_a == 3'd0;
  assign w_wr_stat = csr_write_i && w_a == 3'd1;
  assign w_wr_str  = csr_write_i && w_a == 3'd2;
  assign w_wr_cnt  = csr_write_i && w_a == 3'd3;
  assign w_wr_mask = csr_write_i && w_a == 3'd4;
  assign w_smin    = csr_writedata_i[7:0];
  assign w_smax    = csr_writedata_i[15:8];
  assign w_str_ok  = w_smin >= 8'(MIN_STR_SIZE) && w_smax <= 8'(MAX_STR_SIZE) && w_smin <= w_smax;
  assign w_hash_idx = lut_host_address_i[LUT_ADDR_W+7:LUT_ADDR_W];
  assign w_hash_ok  = w_hash_idx < 8'(HASHES_CNT);
  assign w_en_nxt   = w_wr_ctrl ? csr_writedata_i[0] : r_en;
  assign lut_host_waitrequest_o = w_busy;
  assign w_unused = ^{csr_address_i, csr_writedata_i, lut_host_address_i, lut_host_writedata_i};
  assign w_rdata = w_a == 3'd0 ? AMM_CSR_DATA_W'(r_en) :
                   w_a == 3'd1 ? AMM_CSR_DATA_W'({r_err, filter_en_o, w_busy}) :
                   w_a == 3'd2 ? AMM_CSR_DATA_W'({max_str_size_o, min_str_size_o}) :
                   w_a == 3'd3 ? AMM_CSR_DATA_W'(r_match_cnt) :
                   w_a == 3'd4 ? AMM_CSR_DATA_W'(hash_mask_o) : '0;
  // The sweep ends once the last LUT address has been presented on the write port
  always_comb begin
    w_state_nxt = S_IDLE;
    if (r_state == S_IDLE)
      w_state_nxt = (w_wr_ctrl && csr_writedata_i[1]) ? S_ARM : S_IDLE;
    else if (r_state == S_ARM)
      w_state_nxt = S_RUN;
    else if (r_state == S_RUN)
      w_state_nxt = (lut_wr_addr_o == '1) ? S_IDLE : S_RUN;
  end
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_state             <= S_IDLE;
      r_en                <= 1'b0;
      r_err               <= 1'b0;
      r_match_cnt         <= '0;
      csr_readdata_o      <= '0;
      csr_readdatavalid_o <= 1'b0;
      lut_wr_o            <= 1'b0;
      lut_wr_hash_o       <= '0;
      lut_wr_addr_o       <= '0;
      lut_wr_data_o       <= 1'b0;
      filter_en_o         <= 1'b0;
      min_str_size_o      <= 8'(MIN_STR_SIZE);
      max_str_size_o      <= 8'(MAX_STR_SIZE);
      hash_mask_o         <= '1;
    end else begin
      r_state             <= w_state_nxt;
      csr_readdatavalid_o <= csr_read_i;
      csr_readdata_o      <= csr_read_i ? w_rdata : '0;
      filter_en_o         <= w_en_nxt && w_state_nxt == S_IDLE;
      if (w_wr_ctrl) r_en <= csr_writedata_i[0];
      if (w_wr_str) begin
        if (w_str_ok) begin
          min_str_size_o <= w_smin;
          max_str_size_o <= w_smax;
        end else r_err <= 1'b1;
      end else if (w_wr_stat && csr_writedata_i[2]) r_err <= 1'b0;
      if (w_wr_cnt) r_match_cnt <= '0;
      else if (match_i && r_match_cnt != '1) r_match_cnt <= r_match_cnt + 32'd1;
      if (w_wr_mask) hash_mask_o <= csr_writedata_i[HASHES_CNT-1:0];
      if (r_state == S_ARM) begin
        lut_wr_o      <= 1'b1;
        lut_wr_hash_o <= '1;
        lut_wr_addr_o <= '0;
        lut_wr_data_o <= 1'b0;
      end else if (r_state == S_RUN) begin
        lut_wr_o      <= w_state_nxt == S_RUN;
        lut_wr_addr_o <= lut_wr_addr_o + 1'b1;
      end else begin
        lut_wr_o <= lut_host_write_i && w_hash_ok;
        if (lut_host_write_i) begin
          lut_wr_addr_o <= lut_host_address_i[LUT_ADDR_W-1:0];
          lut_wr_data_o <= lut_host_writedata_i[0];
          lut_wr_hash_o <= w_hash_ok ? HASHES_CNT'(1) << w_hash_idx : '0;
        end
      end
    end
  end
endmodule
